// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, access sizes,
// FSM states and the legality/alignment helpers used when an access is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_e;

  // Unsigned widths only exist for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return is_load;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return ~off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication plus write strobes, and load byte/half
// extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_strb_o,
  output logic [31:0] st_lanes_o,
  input  size_e       ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    st_strb_o  = 4'hF;
    st_lanes_o = st_data_i;
    case (st_size_i)
      SZ_B: begin
        st_strb_o  = 4'b0001 << st_off_i;
        st_lanes_o = {4{st_data_i[7:0]}};
      end
      SZ_H: begin
        st_strb_o  = 4'b0011 << st_off_i;
        st_lanes_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_byte    = ld_shifted[7:0];
    ld_half    = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    ld_data_o  = ld_rdata_i;
    case (ld_size_i)
      SZ_B: ld_data_o = ld_unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H: ld_data_o = ld_unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store from EX, runs it over a req/ready
// handshake with an optional timeout, and returns formatted load data for writeback.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  size_e             size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wb_valid_q;
  logic [31:0]       wb_data_q;
  logic              fault_q;

  logic        idle;
  logic        one_op;
  logic        start_ok;
  logic        start_bad;
  logic        timeout_hit;
  logic [3:0]  st_strb;
  logic [31:0] st_lanes;
  logic [31:0] ld_data;

  assign idle      = (state_q == S_IDLE);
  assign one_op    = ex_load ^ ex_store;
  assign start_ok  = idle & ex_valid & one_op & f3_legal(funct3, ex_load)
                   & f3_aligned(funct3, addr[1:0]);
  assign start_bad = idle & ex_valid & ~start_ok & (ex_load | ex_store);
  assign timeout_hit = (TIMEOUT > 0) && !mem_ready && (cnt_q == CNT_LAST);

  assign stall     = (idle & start_ok) | (!idle & !mem_ready);
  assign mem_req   = !idle;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign fault     = fault_q;

  lsu_align u_align (
    .st_size_i     (size_e'(funct3[1:0])),
    .st_off_i      (addr[1:0]),
    .st_data_i     (wdata),
    .st_strb_o     (st_strb),
    .st_lanes_o    (st_lanes),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_off_i      (off_q),
    .ld_rdata_i    (mem_rdata),
    .ld_data_o     (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      off_q      <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q <= S_REQ;
            we_q    <= ex_store;
            addr_q  <= {addr[31:2], 2'b00};
            wstrb_q <= ex_store ? st_strb : 4'h0;
            wdata_q <= st_lanes;
            size_q  <= size_e'(funct3[1:0]);
            uns_q   <= funct3[2];
            off_q   <= addr[1:0];
            cnt_q   <= '0;
          end else if (start_bad) begin
            fault_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            state_q <= S_IDLE;
            if (!we_q) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= ld_data;
            end
          end else if (timeout_hit) begin
            state_q <= S_IDLE;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, faults, wait states, timeout, reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, wb_valid, fault, mem_req, mem_we, mem_ready;
  logic [31:0] wb_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_load(ex_load),
    .ex_store(ex_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; funct3 = f3; addr = a; wdata = d;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
  endtask

  // Advance to the next falling edge; callers drive inputs, then wait #1 and sample.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_in(); mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) next_cycle();
    #1;
    checks++; if ({stall, wb_valid, fault, mem_req, mem_we} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl got %b exp 00000", {stall, wb_valid, fault, mem_req, mem_we}); end
    checks++; if ({wb_data, mem_addr, mem_wdata, mem_wstrb} !== 100'b0) begin errors++;
      $display("FAIL reset_data got %h %h %h %h exp all 0", wb_data, mem_addr, mem_wdata, mem_wstrb); end
    next_cycle(); reset = 1'b0;
  endtask

  task automatic test_store_word();
    next_cycle(); drive(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF); #1;
    checks++; if ({stall, mem_req} !== 2'b10) begin errors++;
      $display("FAIL sw_accept stall/req got %b exp 10", {stall, mem_req}); end
    next_cycle(); idle_in(); mem_ready = 1'b1; #1;
    checks++; if ({mem_req, mem_we, stall} !== 3'b110) begin errors++;
      $display("FAIL sw_req req/we/stall got %b exp 110", {mem_req, mem_we, stall}); end
    checks++; if ({mem_addr, mem_wstrb, mem_wdata} !== {32'h100, 4'hF, 32'hDEADBEEF}) begin errors++;
      $display("FAIL sw_bus got %h %h %h exp 00000100 f deadbeef", mem_addr, mem_wstrb, mem_wdata); end
    next_cycle(); mem_ready = 1'b0; #1;
    checks++; if ({mem_req, wb_valid, fault, stall} !== 4'b0) begin errors++;
      $display("FAIL sw_done req/wbv/fault/stall got %b exp 0000", {mem_req, wb_valid, fault, stall}); end
  endtask

  // LB then LBU accepted in the completion's following cycle.
  task automatic test_back_to_back();
    next_cycle(); drive(1'b1, 1'b0, 3'b000, 32'h103, '0); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall got %b exp 1", stall); end
    next_cycle(); idle_in(); mem_ready = 1'b1; mem_rdata = 32'h80FF_1234; #1;
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) begin errors++;
      $display("FAIL lb_req got req %b we %b addr %h exp 1 0 00000100", mem_req, mem_we, mem_addr); end
    next_cycle(); mem_ready = 1'b0; drive(1'b1, 1'b0, 3'b100, 32'h103, '0); #1;
    checks++; if ({wb_valid, wb_data} !== {1'b1, 32'hFFFFFF80}) begin errors++;
      $display("FAIL lb_wb got %b %h exp 1 ffffff80", wb_valid, wb_data); end
    checks++; if ({stall, mem_req} !== 2'b10) begin errors++;
      $display("FAIL lbu_b2b_accept stall/req got %b exp 10", {stall, mem_req}); end
    next_cycle(); idle_in(); mem_ready = 1'b1; #1;
    checks++; if ({mem_req, wb_valid} !== 2'b10) begin errors++;
      $display("FAIL lbu_req req/wbv got %b exp 10", {mem_req, wb_valid}); end
    next_cycle(); mem_ready = 1'b0; #1;
    checks++; if ({wb_valid, wb_data} !== {1'b1, 32'h00000080}) begin errors++;
      $display("FAIL lbu_wb got %b %h exp 1 00000080", wb_valid, wb_data); end
    next_cycle(); #1;
    checks++; if ({wb_valid, mem_req} !== 2'b00) begin errors++;
      $display("FAIL lbu_pulse wbv/req got %b exp 00", {wb_valid, mem_req}); end
  endtask

  task automatic test_store_half();
    next_cycle(); drive(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD);
    next_cycle(); idle_in(); mem_ready = 1'b1; #1;
    checks++; if ({mem_req, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h200, 4'hC, 32'hABCDABCD}) begin
      errors++; $display("FAIL sh_bus got %b %h %h %h exp 1 00000200 c abcdabcd",
                         mem_req, mem_addr, mem_wstrb, mem_wdata); end
    next_cycle(); mem_ready = 1'b0; #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL sh_no_wb got %b exp 0", wb_valid); end
  endtask

  task automatic test_faults();
    logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b100, 3'b000};
    logic [31:0] as  [4] = '{32'h101, 32'h100, 32'h100, 32'h100};
    logic        lds [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        sts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      next_cycle(); drive(lds[i], sts[i], f3s[i], as[i], 32'h1); #1;
      checks++; if ({stall, mem_req} !== 2'b00) begin errors++;
        $display("FAIL fault%0d_accept stall/req got %b exp 00", i, {stall, mem_req}); end
      next_cycle(); idle_in(); #1;
      checks++; if ({fault, mem_req, stall} !== 3'b100) begin errors++;
        $display("FAIL fault%0d_pulse fault/req/stall got %b exp 100", i, {fault, mem_req, stall}); end
      next_cycle(); #1;
      checks++; if ({fault, mem_req} !== 2'b00) begin errors++;
        $display("FAIL fault%0d_clear fault/req got %b exp 00", i, {fault, mem_req}); end
    end
  endtask

  task automatic test_wait_states();
    int wb_count = 0;
    next_cycle(); drive(1'b1, 1'b0, 3'b010, 32'h300, '0); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_wait_c0_stall got %b exp 1", stall); end
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); idle_in(); #1;
      checks++; if ({mem_req, stall, mem_addr} !== {2'b11, 32'h300}) begin errors++;
        $display("FAIL lw_wait_c%0d got req %b stall %b addr %h exp 1 1 00000300", i, mem_req, stall, mem_addr); end
    end
    next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h12345678; #1;
    checks++; if ({mem_req, stall, mem_addr} !== {2'b10, 32'h300}) begin errors++;
      $display("FAIL lw_wait_c4 got req %b stall %b addr %h exp 1 0 00000300", mem_req, stall, mem_addr); end
    next_cycle(); mem_ready = 1'b0; #1;
    checks++; if (wb_data !== 32'h12345678) begin errors++;
      $display("FAIL lw_wait_data got %h exp 12345678", wb_data); end
    if (wb_valid === 1'b1) wb_count++;
    for (int i = 0; i < 3; i++) begin next_cycle(); #1; if (wb_valid === 1'b1) wb_count++; end
    checks++; if (wb_count !== 1) begin errors++;
      $display("FAIL lw_wait_wb_count got %0d exp 1", wb_count); end
  endtask

  task automatic test_timeout();
    next_cycle(); drive(1'b1, 1'b0, 3'b010, 32'h400, '0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); idle_in(); #1;
      checks++; if ({mem_req, stall, fault} !== 3'b110) begin errors++;
        $display("FAIL timeout_c%0d req/stall/fault got %b exp 110", i, {mem_req, stall, fault}); end
    end
    next_cycle(); #1;
    checks++; if ({mem_req, stall, fault, wb_valid} !== 4'b0010) begin errors++;
      $display("FAIL timeout_abort req/stall/fault/wbv got %b exp 0010", {mem_req, stall, fault, wb_valid}); end
    next_cycle(); #1;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b exp 0", fault); end
  endtask

  task automatic test_reset_mid_req();
    next_cycle(); drive(1'b1, 1'b0, 3'b010, 32'h500, '0);
    next_cycle(); idle_in(); #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req_pre got %b exp 1", mem_req); end
    #2; reset = 1'b1; #1;
    checks++; if ({mem_req, stall} !== 2'b00) begin errors++;
      $display("FAIL rst_mid_req_drop req/stall got %b exp 00", {mem_req, stall}); end
    next_cycle(); reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hCAFE0001; #1;
    checks++; if ({wb_valid, fault, mem_req} !== 3'b000) begin errors++;
      $display("FAIL rst_mid_req_quiet wbv/fault/req got %b exp 000", {wb_valid, fault, mem_req}); end
    next_cycle(); mem_ready = 1'b0; drive(1'b1, 1'b0, 3'b010, 32'h504, '0);
    next_cycle(); idle_in(); mem_ready = 1'b1; #1;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h504}) begin errors++;
      $display("FAIL rst_after_lw_req got %b %h exp 1 00000504", mem_req, mem_addr); end
    next_cycle(); mem_ready = 1'b0; #1;
    checks++; if ({wb_valid, wb_data} !== {1'b1, 32'hCAFE0001}) begin errors++;
      $display("FAIL rst_after_lw_wb got %b %h exp 1 cafe0001", wb_valid, wb_data); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_back_to_back();
    test_store_half();
    test_faults();
    test_wait_states();
    test_timeout();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
